ball_controller: RTL and testbench

//   Upstream of the sprite/VGA stage. Owns one ball's position and motion on the
//   640x480 field: moves it once per frame tick and bounces it off the left, right
//   and top walls and off the player bar. Declares game over when the ball passes
//   the bottom edge. Outputs the ball's bounding-box limits and game_state in the

---
 rtl/ball_controller.sv | 144 ++++++++++++++
 tb/tb_ball_controller.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ball_controller.sv
// One ball on a 640x480 field: ticked motion, wall and bar bounces, bottom miss.
// Bounding-box limits and game_state are registered for the sprite stage.
module ball_controller #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BALL_SIZE   = 10,
    parameter int STEP_X      = 2,
    parameter int STEP_Y      = 2,
    parameter int TICK_DIV    = 833333,
    parameter int START_X     = 315,
    parameter int START_Y     = 300,
    parameter int START_DIR_Y = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       launch,
    input  logic [9:0] bar_leftLimit,
    input  logic [9:0] bar_rightLimit,
    input  logic [9:0] bar_topLimit,
    output logic [9:0] ball_leftLimit,
    output logic [9:0] ball_rightLimit,
    output logic [9:0] ball_topLimit,
    output logic [9:0] ball_bottomLimit,
    output logic       game_state
);

    typedef enum logic [1:0] {IDLE, MOVING, GAME_OVER} state_t;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [10:0] X_MAX = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] SX    = 11'(STEP_X);
    localparam logic [10:0] SY    = 11'(STEP_Y);
    localparam logic [10:0] BS    = 11'(BALL_SIZE);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [9:0]    right_q, right_d, bottom_q, bottom_d;
    logic          dx_q, dx_d, dy_q, dy_d;
    logic          go_q, go_d;

    logic          tick;
    logic          hit;
    logic [10:0]   x11, y11, bt11;

    assign tick = (cnt_q == TICK_LAST);
    assign x11  = {1'b0, x_q};
    assign y11  = {1'b0, y_q};
    assign bt11 = {1'b0, bar_topLimit};

    // Bar catches the ball if it overlaps in x and its bottom reaches the bar top this step.
    assign hit = (x11 + BS > {1'b0, bar_leftLimit})
              && (x_q < bar_rightLimit)
              && (y11 + BS <= bt11)
              && (bt11 <= y11 + BS + SY);

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        unique case (state_q)
            IDLE: begin
                if (launch) state_d = MOVING;
            end
            MOVING: begin
                if (tick) begin
                    if (dx_q) begin
                        if (x11 + SX > X_MAX) begin
                            x_d  = X_MAX[9:0];
                            dx_d = 1'b0;
                        end else begin
                            x_d = 10'(x11 + SX);
                        end
                    end else begin
                        if (x11 < SX) begin
                            x_d  = '0;
                            dx_d = 1'b1;
                        end else begin
                            x_d = 10'(x11 - SX);
                        end
                    end
                    if (!dy_q) begin
                        if (y11 < SY) begin
                            y_d  = '0;
                            dy_d = 1'b1;
                        end else begin
                            y_d = 10'(y11 - SY);
                        end
                    end else if (hit) begin
                        y_d  = 10'(bt11 - BS);
                        dy_d = 1'b0;
                    end else if (y11 + SY > Y_MAX) begin
                        state_d = GAME_OVER;
                    end else begin
                        y_d = 10'(y11 + SY);
                    end
                end
            end
            GAME_OVER: begin
                state_d = GAME_OVER;
            end
            default: state_d = IDLE;
        endcase
        right_d  = x_d + 10'(BALL_SIZE);
        bottom_d = y_d + 10'(BALL_SIZE);
        go_d     = (state_d == GAME_OVER);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= 10'(START_X);
            y_q      <= 10'(START_Y);
            right_q  <= 10'(START_X + BALL_SIZE);
            bottom_q <= 10'(START_Y + BALL_SIZE);
            dx_q     <= 1'b1;
            dy_q     <= 1'(START_DIR_Y);
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            right_q  <= right_d;
            bottom_q <= bottom_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            go_q     <= go_d;
        end
    end

    assign ball_leftLimit   = x_q;
    assign ball_rightLimit  = right_q;
    assign ball_topLimit    = y_q;
    assign ball_bottomLimit = bottom_q;
    assign game_state       = go_q;

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller with TICK_DIV=4 on four instances
// covering launch, wall corner, bar bounce, bottom miss and mid-flight reset.
module tb_ball_controller;

    logic       CLOCK_50 = 1'b0;
    logic       rst0, rst5, launch;
    logic [9:0] l0, r0, t0, b0, l3, r3, t3, b3;
    logic [9:0] l4, r4, t4, b4, l5, r5, t5, b5;
    logic       g0, g3, g4, g5;
    int         total = 0;
    int         bad   = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    ball_controller #(.TICK_DIV(4)) u0 (
        .CLOCK_50(CLOCK_50), .reset(rst0), .launch(launch),
        .bar_leftLimit(10'd0), .bar_rightLimit(10'd0), .bar_topLimit(10'd479),
        .ball_leftLimit(l0), .ball_rightLimit(r0),
        .ball_topLimit(t0), .ball_bottomLimit(b0), .game_state(g0));

    ball_controller #(.TICK_DIV(4), .START_X(629), .START_Y(1)) u3 (
        .CLOCK_50(CLOCK_50), .reset(rst0), .launch(launch),
        .bar_leftLimit(10'd0), .bar_rightLimit(10'd0), .bar_topLimit(10'd0),
        .ball_leftLimit(l3), .ball_rightLimit(r3),
        .ball_topLimit(t3), .ball_bottomLimit(b3), .game_state(g3));

    ball_controller #(.TICK_DIV(4), .START_X(320), .START_Y(428),
                      .START_DIR_Y(1)) u4 (
        .CLOCK_50(CLOCK_50), .reset(rst0), .launch(launch),
        .bar_leftLimit(10'd300), .bar_rightLimit(10'd360), .bar_topLimit(10'd440),
        .ball_leftLimit(l4), .ball_rightLimit(r4),
        .ball_topLimit(t4), .ball_bottomLimit(b4), .game_state(g4));

    ball_controller #(.TICK_DIV(4), .START_Y(469), .START_DIR_Y(1)) u5 (
        .CLOCK_50(CLOCK_50), .reset(rst5), .launch(launch),
        .bar_leftLimit(10'd0), .bar_rightLimit(10'd60), .bar_topLimit(10'd470),
        .ball_leftLimit(l5), .ball_rightLimit(r5),
        .ball_topLimit(t5), .ball_bottomLimit(b5), .game_state(g5));

    task automatic chk(input string tag, input logic [10:0] obs,
                       input logic [10:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    initial begin
        rst0 = 1'b0;
        rst5 = 1'b0;
        launch = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        rst0 = 1'b1;
        rst5 = 1'b1;
        chk("rst_left", 11'(l0), 11'd315);
        chk("rst_right", 11'(r0), 11'd325);
        chk("rst_top", 11'(t0), 11'd300);
        chk("rst_bottom", 11'(b0), 11'd310);
        chk("rst_gs", 11'(g0), 11'd0);

        // 20 ticks in IDLE: nothing moves
        cyc(80);
        chk("idle_left", 11'(l0), 11'd315);
        chk("idle_top", 11'(t0), 11'd300);
        chk("idle_gs5", 11'(g5), 11'd0);

        launch = 1'b1;
        cyc(1);
        launch = 1'b0;
        cyc(2);
        chk("pre_tick_left", 11'(l0), 11'd315);
        chk("pre_tick_top", 11'(t0), 11'd300);
        cyc(1);
        chk("t1_left", 11'(l0), 11'd317);
        chk("t1_right", 11'(r0), 11'd327);
        chk("t1_top", 11'(t0), 11'd298);
        chk("t1_bottom", 11'(b0), 11'd308);
        chk("corner1_left", 11'(l3), 11'd630);
        chk("corner1_right", 11'(r3), 11'd640);
        chk("corner1_top", 11'(t3), 11'd0);
        chk("bar_hit_top", 11'(t4), 11'd430);
        chk("bar_hit_bottom", 11'(b4), 11'd440);
        chk("miss_gs", 11'(g5), 11'd1);
        chk("miss_top", 11'(t5), 11'd469);
        cyc(3);
        chk("mid_tick_left", 11'(l0), 11'd317);
        cyc(1);
        chk("t2_left", 11'(l0), 11'd319);
        chk("t2_top", 11'(t0), 11'd296);
        chk("corner2_left", 11'(l3), 11'd628);
        chk("corner2_top", 11'(t3), 11'd2);
        chk("bar_after_top", 11'(t4), 11'd428);
        chk("over_frozen_top", 11'(t5), 11'd469);

        // launch must not revive a finished game
        launch = 1'b1;
        cyc(1);
        launch = 1'b0;
        cyc(11);
        chk("over_launch_top", 11'(t5), 11'd469);
        chk("over_launch_bottom", 11'(b5), 11'd479);
        chk("over_launch_gs", 11'(g5), 11'd1);

        rst5 = 1'b0;
        cyc(1);
        rst5 = 1'b1;
        chk("over_rst_gs", 11'(g5), 11'd0);
        chk("over_rst_left", 11'(l5), 11'd315);
        chk("over_rst_top", 11'(t5), 11'd469);
        cyc(8);
        chk("over_idle_top", 11'(t5), 11'd469);
        chk("over_idle_gs", 11'(g5), 11'd0);

        // u0 reaches top=350 on its way down after tick 326 (edge 1384)
        cyc(1275);
        chk("flight_top", 11'(t0), 11'd350);
        chk("flight_left", 11'(l0), 11'd294);
        rst0 = 1'b0;
        cyc(1);
        chk("midrst_left", 11'(l0), 11'd315);
        chk("midrst_right", 11'(r0), 11'd325);
        chk("midrst_top", 11'(t0), 11'd300);
        chk("midrst_bottom", 11'(b0), 11'd310);
        chk("midrst_gs", 11'(g0), 11'd0);
        rst0 = 1'b1;
        launch = 1'b1;
        cyc(1);
        launch = 1'b0;
        cyc(2);
        chk("cnt0_pre_top", 11'(t0), 11'd300);
        cyc(1);
        chk("cnt0_tick_top", 11'(t0), 11'd298);
        chk("cnt0_tick_left", 11'(l0), 11'd317);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
